// File: rtl/cpu_consts_pkg.sv
// Shared CPU constants: multiplier function encoding and latency bounds.
package cpu_consts;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    MULW   = 3'd4
  } mult_func_t;

  localparam int MUL_LAT_MIN = 2;
  localparam int MUL_LAT_MAX = 8;
  localparam int RD_W        = 5;

endpackage

// File: rtl/mul_pipe_stage.sv
// One payload register of the multiplier pipeline: holds on stall, drops valid on kill.
module mul_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         kill,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (kill) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU/MULW) with stall and kill.
// Optional macro MUL_HAZARD_EN adds the inflight_rd_o destination-register map.
module mul_pipe
  import cpu_consts::*;
#(
  parameter int XLEN    = 64,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [2:0]      mult_func_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            stall_i,
  input  logic            kill_i,
  output logic            valid_o,
  output logic [XLEN-1:0] mult_res_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wr_en_o,
  output logic            busy_o
`ifdef MUL_HAZARD_EN
  ,
  output logic [31:0]     inflight_rd_o
`endif
);

  localparam int PW = XLEN + RD_W;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("mul_pipe: XLEN must be 32 or 64");
  end
  if (LATENCY < MUL_LAT_MIN || LATENCY > MUL_LAT_MAX) begin : g_bad_lat
    $error("mul_pipe: LATENCY must be within 2..8");
  end

  mult_func_t      func_d;
  logic            a_signed_d, b_signed_d;
  logic            s1_valid;
  logic [XLEN-1:0] s1_a, s1_b;
  mult_func_t      s1_func;
  logic [4:0]      s1_rd;
  logic            s1_a_signed, s1_b_signed;

  assign func_d     = mult_func_t'(mult_func_i);
  assign a_signed_d = (func_d == MULH) || (func_d == MULHSU) || (func_d == MULW);
  assign b_signed_d = (func_d == MULH) || (func_d == MULW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_func     <= MUL;
      s1_rd       <= '0;
      s1_a_signed <= 1'b0;
      s1_b_signed <= 1'b0;
    end else if (kill_i) begin
      s1_valid <= 1'b0;
    end else if (!stall_i) begin
      s1_valid    <= valid_i;
      s1_a        <= opr_a_i;
      s1_b        <= opr_b_i;
      s1_func     <= func_d;
      s1_rd       <= rd_addr_i;
      s1_a_signed <= a_signed_d;
      s1_b_signed <= b_signed_d;
    end
  end

  // Low 2*XLEN bits of the (XLEN+1)x(XLEN+1) signed product equal a 2*XLEN-wide
  // product of the same operands extended to 2*XLEN bits.
  logic [2*XLEN-1:0] a_wide, b_wide, prod;
  assign a_wide = {{XLEN{s1_a_signed & s1_a[XLEN-1]}}, s1_a};
  assign b_wide = {{XLEN{s1_b_signed & s1_b[XLEN-1]}}, s1_b};
  assign prod   = a_wide * b_wide;

  logic [XLEN-1:0] mulw_res;
  if (XLEN == 64) begin : g_mulw64
    logic [31:0] mulw_lo;
    assign mulw_lo  = s1_a[31:0] * s1_b[31:0];
    assign mulw_res = {{(XLEN-32){mulw_lo[31]}}, mulw_lo};
  end else begin : g_mulw32
    assign mulw_res = prod[XLEN-1:0];
  end

  logic [XLEN-1:0] res_d;
  always_comb begin
    res_d = '0;
    case (s1_func)
      MUL:                 res_d = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: res_d = prod[2*XLEN-1:XLEN];
      MULW:                res_d = mulw_res;
      default:             res_d = '0;
    endcase
  end

  // Stage 1 feeds index 0; the remaining stages are plain registers for retiming.
  logic [LATENCY-1:0] vld;
  logic [PW-1:0]      pay [LATENCY];

  assign vld[0] = s1_valid;
  assign pay[0] = {s1_rd, res_d};

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
    mul_pipe_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall_i),
      .kill    (kill_i),
      .valid_d (vld[gi-1]),
      .data_d  (pay[gi-1]),
      .valid_q (vld[gi]),
      .data_q  (pay[gi])
    );
  end

  assign valid_o    = vld[LATENCY-1];
  assign mult_res_o = pay[LATENCY-1][XLEN-1:0];
  assign rd_addr_o  = pay[LATENCY-1][PW-1:XLEN];
  assign rd_wr_en_o = valid_o && (rd_addr_o != 5'd0);
  assign busy_o     = |vld;

`ifdef MUL_HAZARD_EN
  always_comb begin
    inflight_rd_o = '0;
    for (int i = 0; i < LATENCY; i++) begin
      if (vld[i]) inflight_rd_o[pay[i][PW-1:XLEN]] = 1'b1;
    end
    inflight_rd_o[0] = 1'b0;
  end
`endif

endmodule
